// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial word transmitter and its matching receiver.
// The frame-length helper keeps both ends agreeing on how many bits a word occupies.
package serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SHIFT
   } ser_state_t;

   localparam int SER_W_DEFAULT = 8;

   // Bits per frame: the word itself, plus the sign-extension tail when that is enabled.
   function automatic int frame_len(input int w, input int ext_bits, input bit sign_ext);
      return sign_ext ? (w + ext_bits) : w;
   endfunction

endpackage

// File: rtl/serial_word_tx.sv
// Parallel-to-serial front end for the bit-serial two's-complement negator: one clear cycle,
// then the word LSB first. Define SER_TX_SIGN_EXT_EN to append EXT_BITS copies of the word's MSB.
module serial_word_tx
   import serial_pkg::*;
#(
   parameter int W        = SER_W_DEFAULT,
   parameter int EXT_BITS = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [W-1:0] s_data,
   output logic         ser_clr,
   output logic         ser_data,
   output logic         ser_valid,
   output logic         ser_last,
   output logic         busy
);

`ifdef SER_TX_SIGN_EXT_EN
   localparam bit SIGN_EXT = 1'b1;
`else
   localparam bit SIGN_EXT = 1'b0;
`endif

   localparam int N  = frame_len(W, EXT_BITS, SIGN_EXT);
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

   ser_state_t    state;
   ser_state_t    state_next;
   logic [W-1:0]  shreg;
   logic [CW-1:0] count;
   logic          accept;
   logic          last_bit;
   logic          refill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Outputs are decoded purely from state so s_ready never looks at s_valid.
   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      ser_clr    = 1'b0;
      ser_valid  = 1'b0;
      ser_data   = 1'b0;
      ser_last   = 1'b0;
      busy       = 1'b1;
      last_bit   = 1'b0;
      case (state)
         ST_IDLE: begin
            busy    = 1'b0;
            s_ready = 1'b1;
            if (s_valid) begin
               state_next = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            ser_clr    = 1'b1;
            state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            last_bit  = (count == LAST_COUNT);
            ser_valid = 1'b1;
            ser_data  = shreg[0];
            ser_last  = last_bit;
            s_ready   = last_bit;
            if (last_bit) begin
               state_next = s_valid ? ST_CLEAR : ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign accept = s_valid && s_ready;

   // Replicating the MSB keeps it in place, so after W shifts the register holds pure sign bits.
   assign refill = SIGN_EXT ? shreg[W-1] : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         count <= '0;
      end else if (accept) begin
         shreg <= s_data;
         count <= '0;
      end else if (state == ST_SHIFT) begin
         shreg <= {refill, shreg[W-1:1]};
         count <= count + CW'(1);
      end
   end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed and randomized checks of serial_word_tx against an arithmetic model of the frame
// and of the downstream negator's result (two's-complement negation modulo 2^N).
module tb_serial_word_tx;

   localparam int W        = serial_pkg::SER_W_DEFAULT;
   localparam int EXT_BITS = 1;
`ifdef SER_TX_SIGN_EXT_EN
   localparam bit EXT = 1'b1;
   localparam int N   = W + EXT_BITS;
`else
   localparam bit EXT = 1'b0;
   localparam int N   = W;
`endif
   localparam longint M = longint'(1) << N;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         s_valid = 1'b0;
   logic [W-1:0] s_data = '0;
   logic         s_ready;
   logic         ser_clr;
   logic         ser_data;
   logic         ser_valid;
   logic         ser_last;
   logic         busy;

   int assert_count = 0;
   int fail_count   = 0;
   int cyc          = 0;

   serial_word_tx #(.W(W), .EXT_BITS(EXT_BITS)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .ser_clr  (ser_clr),
      .ser_data (ser_data),
      .ser_valid(ser_valid),
      .ser_last (ser_last),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assert_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Value of the word as the negator sees it, reduced to an N-bit frame.
   function automatic longint frame_model(input logic [W-1:0] w);
      longint v;
      v = longint'(w);
      if (EXT && w[W-1]) v = v - (longint'(1) << W);
      return ((v % M) + M) % M;
   endfunction

   function automatic longint negate_model(input longint x);
      return (M - x) % M;
   endfunction

   task automatic start_word(input logic [W-1:0] w);
      s_valid = 1'b1;
      s_data  = w;
      check("idle_ready", s_ready, 1);
   endtask

   // Entered right after the handshake inputs are driven; returns at the negedge after the frame.
   task automatic collect_frame(input logic [W-1:0] word, input logic [W-1:0] next_data,
                                input bit keep_valid, output longint frame, output int clr_cyc);
      int waited = 0;
      frame   = 0;
      clr_cyc = -1;
      @(negedge clk);
      while (ser_clr !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("clr_seen", ser_clr, 1);
      if (ser_clr !== 1'b1) return;
      clr_cyc = cyc;
      check("clr_valid_low", ser_valid, 0);
      check("clr_data_low", ser_data, 0);
      s_data  = next_data;
      s_valid = keep_valid;
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         check("bit_valid", ser_valid, 1);
         check("no_clr_mid", ser_clr, 0);
         check("last_flag", ser_last, (i == N - 1));
         check("shift_ready", s_ready, (i == N - 1));
         if (ser_data === 1'b1) frame = frame | (longint'(1) << i);
         if (!keep_valid) begin
            s_data  = W'($urandom);
            s_valid = (i < N - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      check("frame", frame, frame_model(word));
      if (!keep_valid) begin
         @(negedge clk);
         check("post_idle_busy", busy, 0);
         check("post_idle_ready", s_ready, 1);
         check("post_idle_clr", ser_clr, 0);
      end
   endtask

   initial begin
      longint f1, f2;
      int     c1, c2;
      logic [W-1:0] cur, nxt;
      bit keep;

      // Reset state
      #2 rst = 1'b1;
      #1;
      check("rst_ready", s_ready, 1);
      check("rst_clr", ser_clr, 0);
      check("rst_valid", ser_valid, 0);
      check("rst_data", ser_data, 0);
      check("rst_last", ser_last, 0);
      check("rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1: single word 0x05
      start_word(8'h05);
      collect_frame(8'h05, 8'h00, 1'b0, f1, c1);
      check("t1_neg", negate_model(f1), EXT ? 64'h1FB : 64'hFB);

      // 2: back-to-back 0x01 then 0x80 with s_valid held
      start_word(8'h01);
      collect_frame(8'h01, 8'h80, 1'b1, f1, c1);
      collect_frame(8'h80, 8'h00, 1'b0, f2, c2);
      check("t2_period", c2 - c1, N + 1);
      check("t2_neg_a", negate_model(f1), EXT ? 64'h1FF : 64'hFF);
      check("t2_neg_b", negate_model(f2), 64'h80);

`ifdef SER_TX_SIGN_EXT_EN
      // 3: sign extension of the most negative word
      start_word(8'h80);
      collect_frame(8'h80, 8'h00, 1'b0, f1, c1);
      check("t3_ext_bit", (f1 >> (N - 1)) & 1, 1);
      check("t3_neg", negate_model(f1), 64'h080);
`endif

      // 4: s_data/s_valid wiggle during the frame (done inside collect_frame)
      start_word(8'h5C);
      collect_frame(8'h5C, 8'hFF, 1'b0, f1, c1);

      // 5: reset after bit 3 of 0xAA
      start_word(8'hAA);
      @(negedge clk);
      check("t5_clr", ser_clr, 1);
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_mid_valid", ser_valid, 1);
      rst = 1'b1;
      #1;
      check("t5_async_valid", ser_valid, 0);
      check("t5_async_busy", busy, 0);
      check("t5_async_last", ser_last, 0);
      check("t5_async_ready", s_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_hold_last", ser_last, 0);
         check("t5_hold_clr", ser_clr, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      start_word(8'h03);
      collect_frame(8'h03, 8'h00, 1'b0, f1, c1);
      check("t5_neg", negate_model(f1), EXT ? 64'h1FD : 64'hFD);

      // 6: idle for 20 cycles
      s_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t6_idle", {ser_valid, ser_clr, busy, s_ready}, 4'b0001);
      end

      // Randomized words, randomly chained back-to-back
      cur = W'($urandom);
      start_word(cur);
      for (int k = 0; k < 16; k++) begin
         nxt  = W'($urandom);
         keep = (k < 15) && ($urandom_range(0, 1) == 1);
         collect_frame(cur, nxt, keep, f1, c1);
         check("rand_neg", negate_model(f1), negate_model(frame_model(cur)));
         if (!keep && k < 15) start_word(nxt);
         cur = nxt;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
